// File: rtl/aer_pkg.sv
// Shared constants for the AER spike arbiter: state encoding, request types, width helper.
package aer_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t S_ARB      = 2'd0;
  localparam arb_state_t S_HOLD     = 2'd1;
  localparam arb_state_t S_FINALIZE = 2'd2;
  localparam arb_state_t S_DONE     = 2'd3;

  localparam logic REQ_SPIKE = 1'b0;
  localparam logic REQ_EOF   = 1'b1;

  // Downstream address width: {source index, local address}.
  function automatic int unsigned out_addr_w(input int unsigned num_src,
                                             input int unsigned num_inputs);
    return $clog2(num_src) + $clog2(num_inputs);
  endfunction

endpackage

// File: rtl/aer_rr_picker.sv
// Round-robin picker: first set request bit at or after ptr, wrapping modulo NUM_SRC.
module aer_rr_picker #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [NUM_SRC-1:0]         grant,
  output logic [$clog2(NUM_SRC)-1:0] idx,
  output logic                       valid
);
  localparam int unsigned SW = $clog2(NUM_SRC);
  localparam int unsigned PW = SW + 1;

  always_comb begin
    logic [PW-1:0] pos;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = PW'(ptr) + PW'(k);
      if (pos >= PW'(NUM_SRC)) pos = pos - PW'(NUM_SRC);
      if (!valid && req[pos[SW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[SW-1:0];
      end
    end
    grant[idx] = valid;
  end

endmodule

// File: rtl/aer_spike_arbiter.sv
// Merges NUM_SRC AER spike streams onto one link; end-of-frame is emitted once all sources finish.
// Define AER_ARB_EARLIEST_FIRST_EN to serve the earliest signed spike time first.
module aer_spike_arbiter
  import aer_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned NUM_INPUTS = 64,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          i_clk_enable,
  input  logic [NUM_SRC-1:0]                            i_req,
  input  logic [NUM_SRC-1:0]                            i_req_type,
  input  logic [NUM_SRC*DATA_W-1:0]                     i_spike_time,
  input  logic [NUM_SRC*$clog2(NUM_INPUTS)-1:0]         i_spike_addr,
  output logic [NUM_SRC-1:0]                            o_ack,
  output logic                                          o_req,
  input  logic                                          i_ack,
  output logic                                          o_req_type,
  output logic signed [DATA_W-1:0]                      o_spike_time,
  output logic [out_addr_w(NUM_SRC, NUM_INPUTS)-1:0]    o_spike_addr,
  output logic                                          o_done
);
  localparam int unsigned SW = $clog2(NUM_SRC);
  localparam int unsigned AW = $clog2(NUM_INPUTS);
  localparam int unsigned OW = out_addr_w(NUM_SRC, NUM_INPUTS);

  arb_state_t               state_q, state_d;
  logic [SW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0]       eof_q, eof_d;
  logic signed [DATA_W-1:0] time_q, time_d;
  logic [OW-1:0]            addr_q, addr_d;

  logic [NUM_SRC-1:0]       eligible, pick_req, pick_grant, win_grant, ack;
  logic [SW-1:0]            pick_idx, win_idx;
  logic                     pick_valid;

  assign eligible = i_req & ~eof_q;

`ifdef AER_ARB_EARLIEST_FIRST_EN
  localparam int unsigned PW = SW + 1;
  logic [NUM_SRC-1:0] spike_elig;

  // End-of-frame requests compete only when no spike is eligible.
  assign spike_elig = eligible & ~i_req_type;
  assign pick_req   = (|spike_elig) ? spike_elig : eligible;

  // Strict less-than while scanning in rotation order keeps ties with the round-robin winner.
  always_comb begin
    logic [PW-1:0]            pos;
    logic signed [DATA_W-1:0] best;
    logic signed [DATA_W-1:0] cand;
    win_idx = pick_idx;
    best    = i_spike_time[int'(pick_idx)*DATA_W +: DATA_W];
    pos     = '0;
    cand    = '0;
    if (|spike_elig) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        pos = PW'(rr_ptr_q) + PW'(k);
        if (pos >= PW'(NUM_SRC)) pos = pos - PW'(NUM_SRC);
        cand = i_spike_time[int'(pos[SW-1:0])*DATA_W +: DATA_W];
        if (spike_elig[pos[SW-1:0]] && (cand < best)) begin
          best    = cand;
          win_idx = pos[SW-1:0];
        end
      end
    end
    win_grant = (win_idx == pick_idx) ? pick_grant : (NUM_SRC'(1) << win_idx);
  end
`else
  assign pick_req  = eligible;
  assign win_idx   = pick_idx;
  assign win_grant = pick_grant;
`endif

  aer_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next state; nothing advances and no ack is issued while the enable is low or reset is held.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    eof_d    = eof_q;
    time_d   = time_q;
    addr_d   = addr_q;
    ack      = '0;
    if (rst_n && i_clk_enable) begin
      case (state_q)
        S_ARB: begin
          if (pick_valid) begin
            ack      = win_grant;
            rr_ptr_d = (win_idx == SW'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
            if (i_req_type[win_idx] == REQ_EOF) begin
              eof_d[win_idx] = 1'b1;
            end else begin
              time_d  = i_spike_time[int'(win_idx)*DATA_W +: DATA_W];
              addr_d  = {win_idx, i_spike_addr[int'(win_idx)*AW +: AW]};
              state_d = S_HOLD;
            end
          end else if (&eof_q) begin
            state_d = S_FINALIZE;
          end
        end
        S_HOLD: begin
          if (i_ack) begin
            state_d = S_ARB;
            time_d  = '0;
            addr_d  = '0;
          end
        end
        S_FINALIZE: begin
          if (i_ack) state_d = S_DONE;
        end
        S_DONE: begin
          eof_d   = '0;
          state_d = S_ARB;
        end
        default: state_d = S_ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_ARB;
      rr_ptr_q <= '0;
      eof_q    <= '0;
      time_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      eof_q    <= eof_d;
      time_q   <= time_d;
      addr_q   <= addr_d;
    end
  end

  assign o_ack        = ack;
  assign o_req        = (state_q == S_HOLD) || (state_q == S_FINALIZE);
  assign o_req_type   = (state_q == S_FINALIZE);
  assign o_done       = (state_q == S_DONE);
  assign o_spike_time = time_q;
  assign o_spike_addr = addr_q;

endmodule

// File: tb/tb_aer_spike_arbiter.sv
// Self-checking bench for aer_spike_arbiter: vector table, directed corner cases, random vs model.
module tb_aer_spike_arbiter;
  localparam int unsigned NS  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AWL = 6;
  localparam int unsigned OW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, en, ack_in;
  logic [NS-1:0]         req, rtype, ack;
  logic [NS*DW-1:0]      time_bus;
  logic [NS*AWL-1:0]     addr_bus;
  logic signed [DW-1:0]  t_time [NS];
  logic [AWL-1:0]        t_addr [NS];
  logic                  o_req, o_req_type, o_done;
  logic [DW-1:0]         o_time;
  logic [OW-1:0]         o_addr;

  for (genvar g = 0; g < NS; g++) begin : g_flat
    assign time_bus[g*DW +: DW]   = t_time[g];
    assign addr_bus[g*AWL +: AWL] = t_addr[g];
  end

  aer_spike_arbiter #(.NUM_SRC(NS), .NUM_INPUTS(64), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clk_enable (en),
    .i_req        (req),
    .i_req_type   (rtype),
    .i_spike_time (time_bus),
    .i_spike_addr (addr_bus),
    .o_ack        (ack),
    .o_req        (o_req),
    .i_ack        (ack_in),
    .o_req_type   (o_req_type),
    .o_spike_time (o_time),
    .o_spike_addr (o_addr),
    .o_done       (o_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending output spike, finalize/done phases, set of finished sources.
  int            m_ptr;
  logic [NS-1:0] m_eof;
  bit            m_pend, m_fin, m_done;
  logic [DW-1:0] m_time;
  logic [OW-1:0] m_addr;

  function automatic int pick();
    int w;
    int s;
    w = -1;
`ifdef AER_ARB_EARLIEST_FIRST_EN
    for (int k = 0; k < NS; k++) begin
      s = (m_ptr + k) % NS;
      if (req[s] && !m_eof[s] && !rtype[s] && (w < 0 || t_time[s] < t_time[w])) w = s;
    end
    if (w >= 0) return w;
`endif
    for (int k = 0; k < NS; k++) begin
      s = (m_ptr + k) % NS;
      if (req[s] && !m_eof[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_eof = '0; m_pend = 0; m_fin = 0; m_done = 0;
    m_time = '0; m_addr = '0;
  endtask

  task automatic sample();
    logic [NS-1:0] e_ack;
    int w;
    @(negedge clk);
    w = pick();
    e_ack = '0;
    if (rst_n && en && !m_pend && !m_fin && !m_done && w >= 0) e_ack[w] = 1'b1;
    chk("m_ack",      64'(ack),        64'(e_ack));
    chk("m_req",      64'(o_req),      64'(m_pend | m_fin));
    chk("m_req_type", 64'(o_req_type), 64'(m_fin));
    chk("m_done",     64'(o_done),     64'(m_done));
    chk("m_time",     64'(o_time),     64'(m_pend ? m_time : '0));
    chk("m_addr",     64'(o_addr),     64'(m_pend ? m_addr : '0));
  endtask

  task automatic advance();
    int w;
    w = pick();
    if (!rst_n) begin
      model_reset();
    end else if (en) begin
      if (m_done) begin
        m_done = 0; m_eof = '0;
      end else if (m_fin) begin
        if (ack_in) begin m_fin = 0; m_done = 1; end
      end else if (m_pend) begin
        if (ack_in) m_pend = 0;
      end else if (w >= 0) begin
        m_ptr = (w + 1) % NS;
        if (rtype[w]) m_eof[w] = 1'b1;
        else begin
          m_pend = 1; m_time = t_time[w]; m_addr = {2'(w), t_addr[w]};
        end
      end else if (&m_eof) begin
        m_fin = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rtype = '0;
    sample();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic set_default_data();
    t_time[0] = 100; t_time[1] = 10; t_time[2] = -20; t_time[3] = 3;
    t_addr[0] = 2;   t_addr[1] = 5;  t_addr[2] = 9;   t_addr[3] = 7;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rtype;
    logic        ack_in;
    logic [3:0]  e_ack;
    logic        e_req;
    logic        e_type;
    logic        e_done;
    logic [7:0]  e_addr;
    logic [31:0] e_time;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[1]  = '{4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h45, 32'd10};
    tbl[2]  = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 8'hC7, 32'd3};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[5]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[6]  = '{4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[8]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[9]  = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[10] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[11] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 32'd0};
    tbl[12] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 32'd0};
    tbl[13] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0};
    tbl[14] = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};
    tbl[15] = '{4'b1110, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h02, 32'd100};
    tbl[16] = '{4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0};

    rst_n = 1'b0; en = 1'b1; ack_in = 1'b0; req = '0; rtype = '0;
    set_default_data();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Reset state
    sample();
    chk("rst_req",  64'(o_req),  64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_addr", 64'(o_addr), 64'(0));
    chk("rst_time", 64'(o_time), 64'(0));
    advance();

    // Vector table: two-spike handoff, staggered end-of-frame, finalize and done.
    for (int i = 0; i < 17; i++) begin
      req = tbl[i].req; rtype = tbl[i].rtype; ack_in = tbl[i].ack_in;
      sample();
`ifndef AER_ARB_EARLIEST_FIRST_EN
      chk("tbl_ack",  64'(ack),        64'(tbl[i].e_ack));
      chk("tbl_req",  64'(o_req),      64'(tbl[i].e_req));
      chk("tbl_type", 64'(o_req_type), 64'(tbl[i].e_type));
      chk("tbl_done", 64'(o_done),     64'(tbl[i].e_done));
      chk("tbl_addr", 64'(o_addr),     64'(tbl[i].e_addr));
      chk("tbl_time", 64'(o_time),     64'(tbl[i].e_time));
`endif
      advance();
    end

    // Rotation with all four sources requesting; equal times keep the earliest-first build round-robin too.
    do_reset();
    for (int s = 0; s < NS; s++) t_time[s] = 7;
    req = 4'b1111; rtype = '0; ack_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [3:0] e;
      e = (i % 2 == 0) ? (4'b0001 << ((i / 2) % 4)) : 4'b0000;
      sample();
      chk("rot_ack", 64'(ack), 64'(e));
      advance();
    end

    // Downstream stall for 10 cycles in HOLD.
    set_default_data();
    do_reset();
    req = 4'b0100; ack_in = 1'b0;
    sample();
    chk("stall_grant", 64'(ack), 64'(4'b0100));
    advance();
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("stall_ack",  64'(ack),    64'(0));
      chk("stall_req",  64'(o_req),  64'(1));
      chk("stall_addr", 64'(o_addr), 64'(8'h89));
      chk("stall_time", 64'(o_time), 64'(32'hFFFF_FFEC));
      advance();
    end
    ack_in = 1'b1;
    sample();
    advance();
    sample();
    chk("stall_next", 64'(ack), 64'(4'b0001));
    advance();

    // Reset during HOLD drops the in-flight spike and clears end-of-frame history.
    do_reset();
    req = 4'b0001; rtype = 4'b0001; ack_in = 1'b0;
    sample();
    chk("mid_eof", 64'(ack), 64'(4'b0001));
    advance();
    req = 4'b0010; rtype = '0;
    sample();
    advance();
    rst_n = 1'b0; req = '0;
    sample();
    chk("mid_hold", 64'(o_req), 64'(1));
    advance();
    rst_n = 1'b1; ack_in = 1'b1;
    sample();
    chk("mid_req",  64'(o_req),  64'(0));
    chk("mid_addr", 64'(o_addr), 64'(0));
    chk("mid_time", 64'(o_time), 64'(0));
    advance();
    req = 4'b0001; rtype = 4'b0001;
    sample();
    chk("mid_eof_cleared", 64'(ack), 64'(4'b0001));
    advance();
    req = '0; rtype = '0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("mid_no_reemit", 64'(o_req), 64'(0));
      advance();
    end

`ifdef AER_ARB_EARLIEST_FIRST_EN
    do_reset();
    t_time[0] = 50; t_time[2] = -4;
    req = 4'b0101; rtype = '0; ack_in = 1'b1;
    sample();
    chk("ef_ack", 64'(ack), 64'(4'b0100));
    advance();
    req = 4'b0001;
    sample();
    chk("ef_addr", 64'(o_addr), 64'({2'd2, 6'd9}));
    advance();
    set_default_data();
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 199) != 0);
      ack_in = 1'($urandom_range(0, 1));
      req    = 4'($urandom_range(0, 15));
      for (int s = 0; s < NS; s++) begin
        rtype[s]  = ($urandom_range(0, 5) == 0);
        t_time[s] = $urandom;
        t_addr[s] = 6'($urandom_range(0, 63));
      end
      sample();
      advance();
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
